frame_parser: RTL and testbench

FRAME_PARSER -- requirements
Module: frame_parser

---
 rtl/frame_parser.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_frame_parser.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_parser.sv
// ---------------------------------------------------------------------------
// frame_parser
//
// Receive-side Ethernet frame parser for a GMII byte stream. Strips the
// preamble/SFD, extracts the DA, SA and length/type header fields, counts
// frame bytes, checks the CRC-32 FCS and reports a one-cycle end-of-frame
// status. Post-SFD bytes are forwarded through a fixed-latency delay line
// with start/end-of-frame markers.
//
// Parameters
//   MAX_LEN  largest good frame in bytes (DA through FCS)
//   MIN_LEN  smallest good frame in bytes (DA through FCS)
//   DLY      data-path latency in clock cycles (>= 2)
//
// Ports
//   iclk          clock, rising edge
//   irst_n        asynchronous active-low reset
//   irx_data      GMII receive byte
//   irx_dv        receive data valid
//   irx_er        receive error
//   o_state       parser state encoding
//   o_data        forwarded frame byte
//   o_dv          o_data valid
//   o_sof         first DA byte on o_data
//   o_eof         last FCS byte on o_data
//   o_da          destination address, first byte in [47:40]
//   o_sa          source address, first byte in [47:40]
//   o_len_type    length/type, first byte in [15:8]
//   o_hdr_vld     one-cycle pulse when the header fields update
//   o_frame_len   byte count DA through FCS
//   o_status_vld  one-cycle end-of-frame status pulse
//   o_good        frame error-free (valid with o_status_vld)
//   o_err_code    error reason (valid with o_status_vld)
// ---------------------------------------------------------------------------
module frame_parser #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter int DLY     = 4
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic [7:0]  irx_data,
  input  logic        irx_dv,
  input  logic        irx_er,
  output logic [2:0]  o_state,
  output logic [7:0]  o_data,
  output logic        o_dv,
  output logic        o_sof,
  output logic        o_eof,
  output logic [47:0] o_da,
  output logic [47:0] o_sa,
  output logic [15:0] o_len_type,
  output logic        o_hdr_vld,
  output logic [10:0] o_frame_len,
  output logic        o_status_vld,
  output logic        o_good,
  output logic [2:0]  o_err_code
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DA   = 3'd2;
  localparam logic [2:0] S_SA   = 3'd3;
  localparam logic [2:0] S_LEN  = 3'd4;
  localparam logic [2:0] S_DATA = 3'd5;
  localparam logic [2:0] S_DROP = 3'd6;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_PRE   = 3'd1;
  localparam logic [2:0] E_RXER  = 3'd2;
  localparam logic [2:0] E_RUNT  = 3'd3;
  localparam logic [2:0] E_GIANT = 3'd4;
  localparam logic [2:0] E_FCS   = 3'd5;
  localparam logic [2:0] E_ABORT = 3'd6;

  localparam logic [10:0] MAX_LEN_C   = 11'(MAX_LEN);
  localparam logic [10:0] MIN_LEN_C   = 11'(MIN_LEN);
  localparam logic [10:0] CNT_SAT     = 11'h7FF;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  // MSB-first CRC-32 register fed with each byte LSB first. This is the
  // register-orientation of the reflected IEEE 802.3 CRC, so a frame with a
  // correct FCS leaves the well-known 0xC704DD7B residue.
  function automatic logic [31:0] crcStep(input logic [31:0] crcIn,
                                          input logic [7:0]  dataIn);
    logic [31:0] c;
    logic        fb;
    c = crcIn;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ dataIn[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return c;
  endfunction

  logic [2:0]  state_q,     state_d;
  logic        armed_q,     armed_d;
  logic        silent_q,    silent_d;
  logic [2:0]  preCnt_q,    preCnt_d;
  logic        sfdSeen_q,   sfdSeen_d;
  logic [10:0] byteCnt_q,   byteCnt_d;
  logic        rxErr_q,     rxErr_d;
  logic        preErr_q,    preErr_d;
  logic        giant_q,     giant_d;
  logic [31:0] crc_q,       crc_d;
  logic [47:0] daAcc_q,     daAcc_d;
  logic [47:0] saAcc_q,     saAcc_d;
  logic [7:0]  lenHi_q,     lenHi_d;
  logic [47:0] da_q,        da_d;
  logic [47:0] sa_q,        sa_d;
  logic [15:0] lenType_q,   lenType_d;
  logic        hdrVld_q,    hdrVld_d;
  logic [10:0] frameLen_q,  frameLen_d;
  logic        good_q,      good_d;
  logic [2:0]  errCode_q,   errCode_d;
  logic        statusVld_q, statusVld_d;

  logic [DLY-1:0][7:0] pipeData_q;
  logic [DLY-1:0]      pipeFlag_q;
  logic                lastFlag_q;

  logic [10:0] cntInc;
  logic        fwd;
  logic [2:0]  endCode;

  // Parser next-state logic. armed_q blocks a frame from starting until
  // irx_dv has been seen low at least once after reset, so a stream that is
  // already running at reset release is dropped silently. silent_q marks
  // that drop so it produces no status.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    silent_d    = silent_q;
    preCnt_d    = preCnt_q;
    sfdSeen_d   = sfdSeen_q;
    byteCnt_d   = byteCnt_q;
    rxErr_d     = rxErr_q;
    preErr_d    = preErr_q;
    giant_d     = giant_q;
    crc_d       = crc_q;
    daAcc_d     = daAcc_q;
    saAcc_d     = saAcc_q;
    lenHi_d     = lenHi_q;
    da_d        = da_q;
    sa_d        = sa_q;
    lenType_d   = lenType_q;
    hdrVld_d    = 1'b0;
    frameLen_d  = frameLen_q;
    good_d      = good_q;
    errCode_d   = errCode_q;
    statusVld_d = 1'b0;
    fwd         = 1'b0;
    endCode     = E_NONE;
    cntInc      = (byteCnt_q == CNT_SAT) ? byteCnt_q : byteCnt_q + 11'd1;

    if (!irx_dv) armed_d = 1'b1;
    if ((state_q != S_IDLE) && irx_er) rxErr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (irx_dv) begin
          if (armed_q) begin
            state_d   = S_PRE;
            preCnt_d  = 3'd0;
            sfdSeen_d = 1'b0;
            rxErr_d   = 1'b0;
            preErr_d  = 1'b0;
            giant_d   = 1'b0;
            byteCnt_d = 11'd0;
          end else begin
            state_d  = S_DROP;
            silent_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (irx_dv) begin
          if (irx_data == 8'h55) begin
            if (preCnt_q == 3'd7) begin
              preErr_d = 1'b1;
              state_d  = S_DROP;
            end else begin
              preCnt_d = preCnt_q + 3'd1;
            end
          end else if (irx_data == 8'hD5) begin
            state_d   = S_DA;
            sfdSeen_d = 1'b1;
            byteCnt_d = 11'd0;
            crc_d     = CRC_INIT;
          end else begin
            preErr_d = 1'b1;
            state_d  = S_DROP;
          end
        end
      end
      S_DA, S_SA, S_LEN, S_DATA: fwd = irx_dv;
      S_DROP: fwd = irx_dv & sfdSeen_q & ~silent_q;
      default: state_d = S_IDLE;
    endcase

    // Header capture; byteCnt_q is the post-SFD index of the current byte.
    if (irx_dv) begin
      case (state_q)
        S_DA: begin
          daAcc_d = {daAcc_q[39:0], irx_data};
          if (byteCnt_q == 11'd5) state_d = S_SA;
        end
        S_SA: begin
          saAcc_d = {saAcc_q[39:0], irx_data};
          if (byteCnt_q == 11'd11) state_d = S_LEN;
        end
        S_LEN: begin
          if (byteCnt_q == 11'd12) begin
            lenHi_d = irx_data;
          end else if (byteCnt_q == 11'd13) begin
            da_d      = daAcc_q;
            sa_d      = saAcc_q;
            lenType_d = {lenHi_q, irx_data};
            hdrVld_d  = 1'b1;
            state_d   = S_DATA;
          end
        end
        default: ;
      endcase
    end

    // Forwarded bytes are counted and CRC'd even after a giant drop.
    if (fwd) begin
      byteCnt_d = cntInc;
      crc_d     = crcStep(crc_q, irx_data);
      if ((state_q != S_DROP) && (cntInc > MAX_LEN_C)) begin
        giant_d = 1'b1;
        state_d = S_DROP;
      end
    end

    // End of frame: the first edge sampling irx_dv low in any active state.
    if ((state_q != S_IDLE) && !irx_dv) begin
      state_d  = S_IDLE;
      silent_d = 1'b0;
      if (!silent_q) begin
        if (rxErr_q || irx_er)                     endCode = E_RXER;
        else if (preErr_q)                         endCode = E_PRE;
        else if ((state_q == S_PRE) || (state_q == S_DA) ||
                 (state_q == S_SA)  || (state_q == S_LEN))
                                                   endCode = E_ABORT;
        else if (giant_q)                          endCode = E_GIANT;
        else if (byteCnt_q < MIN_LEN_C)            endCode = E_RUNT;
        else if (crc_q != CRC_RESIDUE)             endCode = E_FCS;
        else                                       endCode = E_NONE;
        statusVld_d = 1'b1;
        frameLen_d  = byteCnt_q;
        errCode_d   = endCode;
        good_d      = (endCode == E_NONE);
      end
    end
  end

  // Parser state, counters, CRC, header fields and status registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      silent_q    <= 1'b0;
      preCnt_q    <= 3'd0;
      sfdSeen_q   <= 1'b0;
      byteCnt_q   <= 11'd0;
      rxErr_q     <= 1'b0;
      preErr_q    <= 1'b0;
      giant_q     <= 1'b0;
      crc_q       <= 32'd0;
      daAcc_q     <= 48'd0;
      saAcc_q     <= 48'd0;
      lenHi_q     <= 8'd0;
      da_q        <= 48'd0;
      sa_q        <= 48'd0;
      lenType_q   <= 16'd0;
      hdrVld_q    <= 1'b0;
      frameLen_q  <= 11'd0;
      good_q      <= 1'b0;
      errCode_q   <= 3'd0;
      statusVld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      silent_q    <= silent_d;
      preCnt_q    <= preCnt_d;
      sfdSeen_q   <= sfdSeen_d;
      byteCnt_q   <= byteCnt_d;
      rxErr_q     <= rxErr_d;
      preErr_q    <= preErr_d;
      giant_q     <= giant_d;
      crc_q       <= crc_d;
      daAcc_q     <= daAcc_d;
      saAcc_q     <= saAcc_d;
      lenHi_q     <= lenHi_d;
      da_q        <= da_d;
      sa_q        <= sa_d;
      lenType_q   <= lenType_d;
      hdrVld_q    <= hdrVld_d;
      frameLen_q  <= frameLen_d;
      good_q      <= good_d;
      errCode_q   <= errCode_d;
      statusVld_q <= statusVld_d;
    end
  end

  // DLY-stage delay line; lastFlag_q holds the flag that left the output
  // stage one cycle earlier, for start-of-frame detection.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      pipeData_q <= '0;
      pipeFlag_q <= '0;
      lastFlag_q <= 1'b0;
    end else begin
      pipeData_q <= {pipeData_q[DLY-2:0], irx_data};
      pipeFlag_q <= {pipeFlag_q[DLY-2:0], fwd};
      lastFlag_q <= pipeFlag_q[DLY-1];
    end
  end

  assign o_state      = state_q;
  assign o_data       = pipeData_q[DLY-1];
  assign o_dv         = pipeFlag_q[DLY-1];
  assign o_sof        = pipeFlag_q[DLY-1] & ~lastFlag_q;
  assign o_eof        = pipeFlag_q[DLY-1] & ~pipeFlag_q[DLY-2];
  assign o_da         = da_q;
  assign o_sa         = sa_q;
  assign o_len_type   = lenType_q;
  assign o_hdr_vld    = hdrVld_q;
  assign o_frame_len  = frameLen_q;
  assign o_status_vld = statusVld_q;
  assign o_good       = good_q;
  assign o_err_code   = errCode_q;

endmodule

// File: tb/tb_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_frame_parser
//
// Directed self-checking bench for frame_parser. Frames are assembled with a
// bench-side reflected CRC-32 and driven as GMII bytes; a negedge monitor
// tallies header/status/forwarding events and checks every forwarded byte
// against the expected byte and latency.
// ---------------------------------------------------------------------------
module tb_frame_parser;

  localparam int DLY     = 4;
  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;
  localparam int SETTLE  = DLY + 4;

  logic        iclk     = 1'b0;
  logic        irst_n   = 1'b0;
  logic [7:0]  irx_data = 8'h00;
  logic        irx_dv   = 1'b0;
  logic        irx_er   = 1'b0;
  logic [2:0]  o_state;
  logic [7:0]  o_data;
  logic        o_dv, o_sof, o_eof;
  logic [47:0] o_da, o_sa;
  logic [15:0] o_len_type;
  logic        o_hdr_vld;
  logic [10:0] o_frame_len;
  logic        o_status_vld, o_good;
  logic [2:0]  o_err_code;

  frame_parser #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .DLY(DLY)) dut (
    .iclk(iclk), .irst_n(irst_n), .irx_data(irx_data), .irx_dv(irx_dv),
    .irx_er(irx_er), .o_state(o_state), .o_data(o_data), .o_dv(o_dv),
    .o_sof(o_sof), .o_eof(o_eof), .o_da(o_da), .o_sa(o_sa),
    .o_len_type(o_len_type), .o_hdr_vld(o_hdr_vld),
    .o_frame_len(o_frame_len), .o_status_vld(o_status_vld),
    .o_good(o_good), .o_err_code(o_err_code)
  );

  always #5 iclk = ~iclk;

  logic [142:0] allOut;
  assign allOut = {o_state, o_data, o_dv, o_sof, o_eof, o_da, o_sa,
                   o_len_type, o_hdr_vld, o_frame_len, o_status_vld,
                   o_good, o_err_code};

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] frm[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hdrCnt = 0, statCnt = 0, goodCnt = 0, dvCnt = 0, sofCnt = 0, eofCnt = 0;
  int lastStatCyc = 0, lastSofCyc = 0, lastEofCyc = 0;
  int firstCyc = 0, lastCyc = 0;
  int hdr0, stat0, good0, dv0, sof0, eof0;
  logic [10:0] lastLen = '0;
  logic [2:0]  lastCode = '0;
  logic        lastGood = 1'b0;
  logic [47:0] capDa = '0, capSa = '0;
  logic [15:0] capLt = '0;

  // Cycle number, advanced on every active edge.
  always @(posedge iclk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [159:0] obs,
                             input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampling on the inactive clock edge.
  always @(negedge iclk) begin
    if (o_hdr_vld) begin
      hdrCnt++;
      capDa = o_da;
      capSa = o_sa;
      capLt = o_len_type;
    end
    if (o_status_vld) begin
      statCnt++;
      if (o_good) goodCnt++;
      lastLen     = o_frame_len;
      lastCode    = o_err_code;
      lastGood    = o_good;
      lastStatCyc = cyc;
    end
    if (o_sof) begin
      sofCnt++;
      lastSofCyc = cyc;
    end
    if (o_eof) begin
      eofCnt++;
      lastEofCyc = cyc;
    end
    if (o_dv) begin
      dvCnt++;
      if (expQ.size() == 0) begin
        checkOutput("fwd_unexpected", 160'(o_dv), 160'(0));
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("fwd_data", 160'(o_data), 160'(e.b));
        checkOutput("fwd_latency", 160'(cyc - e.c), 160'(DLY));
      end
    end
  end

  function automatic logic [31:0] crcByte(input logic [31:0] c,
                                          input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Frame of n bytes: fixed header, patterned payload, FCS low byte first.
  task automatic buildFrame(input int n);
    logic [111:0] hdr;
    logic [31:0]  c;
    hdr = 112'h0211_2233_4455_02AA_BBCC_DDEE_0800;
    frm.delete();
    for (int i = 0; i < 14; i++) frm.push_back(hdr[111 - 8*i -: 8]);
    for (int i = 14; i < n - 4; i++) frm.push_back(8'(i * 7 + 3));
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n - 4; i++) c = crcByte(c, frm[i]);
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic driveByte(input logic [7:0] b, input logic dv, input logic er,
                           input bit fwd);
    @(posedge iclk);
    #1;
    irx_data = b;
    irx_dv   = dv;
    irx_er   = er;
    if (fwd) expQ.push_back('{b: b, c: cyc});
  endtask

  task automatic applyStimulus(input int nPre, input int n, input bit flipLast,
                               input int erIdx, input bit fwd, input int gap);
    for (int i = 0; i < nPre; i++) driveByte(8'h55, 1'b1, 1'b0, 1'b0);
    driveByte(8'hD5, 1'b1, 1'b0, 1'b0);
    buildFrame(n);
    if (flipLast) frm[n-1] = frm[n-1] ^ 8'h01;
    for (int i = 0; i < n; i++) begin
      driveByte(frm[i], 1'b1, (i == erIdx), fwd);
      if (i == 0) firstCyc = cyc;
      lastCyc = cyc;
    end
    for (int i = 0; i < gap; i++) driveByte(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic snap();
    hdr0 = hdrCnt; stat0 = statCnt; good0 = goodCnt;
    dv0 = dvCnt; sof0 = sofCnt; eof0 = eofCnt;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    checkOutput("reset_outputs", 160'(allOut), 160'(0));
    @(posedge iclk);
    #1 irst_n = 1'b1;
    driveByte(8'h00, 1'b0, 1'b0, 1'b0);
    driveByte(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge iclk);
    checkOutput("idle_state", 160'(o_state), 160'(0));

    // Good 64-byte frame
    $display("[TB] good 64-byte frame");
    snap();
    applyStimulus(7, 64, 1'b0, -1, 1'b1, SETTLE);
    checkOutput("good_hdr_pulses", 160'(hdrCnt - hdr0), 160'(1));
    checkOutput("good_status_pulses", 160'(statCnt - stat0), 160'(1));
    checkOutput("good_status_cycle", 160'(lastStatCyc), 160'(lastCyc + 2));
    checkOutput("good_len", 160'(lastLen), 160'(64));
    checkOutput("good_good", 160'(lastGood), 160'(1));
    checkOutput("good_code", 160'(lastCode), 160'(0));
    checkOutput("good_da", 160'(capDa), 160'(48'h0211_2233_4455));
    checkOutput("good_sa", 160'(capSa), 160'(48'h02AA_BBCC_DDEE));
    checkOutput("good_lt", 160'(capLt), 160'(16'h0800));
    checkOutput("good_dv_count", 160'(dvCnt - dv0), 160'(64));
    checkOutput("good_sof_count", 160'(sofCnt - sof0), 160'(1));
    checkOutput("good_eof_count", 160'(eofCnt - eof0), 160'(1));
    checkOutput("good_sof_cycle", 160'(lastSofCyc), 160'(firstCyc + DLY));
    checkOutput("good_eof_cycle", 160'(lastEofCyc), 160'(lastCyc + DLY));
    checkOutput("good_end_state", 160'(o_state), 160'(0));

    // Corrupted FCS
    $display("[TB] bad FCS frame");
    snap();
    applyStimulus(7, 64, 1'b1, -1, 1'b1, SETTLE);
    checkOutput("fcs_status_pulses", 160'(statCnt - stat0), 160'(1));
    checkOutput("fcs_code", 160'(lastCode), 160'(5));
    checkOutput("fcs_good", 160'(lastGood), 160'(0));
    checkOutput("fcs_len", 160'(lastLen), 160'(64));
    checkOutput("fcs_dv_count", 160'(dvCnt - dv0), 160'(64));

    // Preamble too long
    $display("[TB] preamble error frame");
    snap();
    applyStimulus(9, 20, 1'b0, -1, 1'b0, SETTLE);
    checkOutput("pre_status_pulses", 160'(statCnt - stat0), 160'(1));
    checkOutput("pre_code", 160'(lastCode), 160'(1));
    checkOutput("pre_dv_count", 160'(dvCnt - dv0), 160'(0));
    checkOutput("pre_hdr_pulses", 160'(hdrCnt - hdr0), 160'(0));

    // Runt
    $display("[TB] runt frame");
    applyStimulus(7, 40, 1'b0, -1, 1'b1, SETTLE);
    checkOutput("runt_code", 160'(lastCode), 160'(3));
    checkOutput("runt_len", 160'(lastLen), 160'(40));

    // Giant
    $display("[TB] giant frame");
    snap();
    applyStimulus(7, 1600, 1'b0, -1, 1'b1, SETTLE);
    checkOutput("giant_code", 160'(lastCode), 160'(4));
    checkOutput("giant_len", 160'(lastLen), 160'(1600));
    checkOutput("giant_dv_count", 160'(dvCnt - dv0), 160'(1600));

    // Receive error mid-frame
    $display("[TB] rx error frame");
    applyStimulus(7, 100, 1'b0, 30, 1'b1, SETTLE);
    checkOutput("rxer_code", 160'(lastCode), 160'(2));
    checkOutput("rxer_good", 160'(lastGood), 160'(0));

    // Back-to-back frames, one-cycle gap
    $display("[TB] back-to-back frames");
    snap();
    applyStimulus(7, 64, 1'b0, -1, 1'b1, 1);
    applyStimulus(7, 64, 1'b0, -1, 1'b1, SETTLE);
    checkOutput("b2b_status_pulses", 160'(statCnt - stat0), 160'(2));
    checkOutput("b2b_good_pulses", 160'(goodCnt - good0), 160'(2));
    checkOutput("b2b_dv_count", 160'(dvCnt - dv0), 160'(128));

    // Reset mid-frame, released while irx_dv is still high
    $display("[TB] reset mid-frame");
    snap();
    for (int i = 0; i < 7; i++) driveByte(8'h55, 1'b1, 1'b0, 1'b0);
    driveByte(8'hD5, 1'b1, 1'b0, 1'b0);
    buildFrame(64);
    for (int i = 0; i < 20; i++) driveByte(frm[i], 1'b1, 1'b0, 1'b1);
    driveByte(frm[20], 1'b1, 1'b0, 1'b0);
    irst_n = 1'b0;
    expQ.delete();
    @(negedge iclk);
    checkOutput("midrst_outputs", 160'(allOut), 160'(0));
    driveByte(frm[21], 1'b1, 1'b0, 1'b0);
    driveByte(frm[22], 1'b1, 1'b0, 1'b0);
    driveByte(frm[23], 1'b1, 1'b0, 1'b0);
    irst_n = 1'b1;
    for (int i = 24; i < 28; i++) driveByte(frm[i], 1'b1, 1'b0, 1'b0);
    @(negedge iclk);
    checkOutput("midrst_drop_state", 160'(o_state), 160'(6));
    for (int i = 28; i < 64; i++) driveByte(frm[i], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < SETTLE; i++) driveByte(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_no_status", 160'(statCnt - stat0), 160'(0));
    snap();
    applyStimulus(7, 64, 1'b0, -1, 1'b1, SETTLE);
    checkOutput("midrst_next_status", 160'(statCnt - stat0), 160'(1));
    checkOutput("midrst_next_code", 160'(lastCode), 160'(0));
    checkOutput("midrst_next_len", 160'(lastLen), 160'(64));
    checkOutput("midrst_next_dv_count", 160'(dvCnt - dv0), 160'(64));

    checkOutput("queue_drained", 160'(expQ.size()), 160'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
